// File: rtl/buffered_uart.sv
// Buffered 8N1-style UART: register host port, TX/RX FIFOs and bit-level TX/RX FSMs.
// Define BUFF_UART_STATUS_EN to add a sticky status register at status_address.

module buffered_uart_fifo #(
    parameter int width = 8,
    parameter int depth = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [width-1:0] wdata_i,
    output logic [width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(depth);

    logic [width-1:0] mem_q [depth];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(depth));
    assign rdata_o = mem_q[rptr_q];

    // Callers only assert push/pop when legal; no accept logic lives here.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    always_ff @(posedge clock) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end
endmodule

module buffered_uart #(
    parameter int clock_freq = 50_000_000,
    parameter int baud_rate  = 115_200,
    parameter int width      = 8,
    parameter int addr_width = 8,
    parameter int rx_address = 3,
    parameter int tx_address = 4,
`ifdef BUFF_UART_STATUS_EN
    parameter int status_address = 5,
`endif
    parameter int fifo_depth = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  rx,
    output logic                  tx,
    input  logic [addr_width-1:0] active_address,
    input  logic                  read_enable,
    input  logic                  write_enable,
    input  logic [width-1:0]      data_in,
    output logic [width-1:0]      data_out,
    output logic                  data_out_valid,
    output logic                  tx_full,
    output logic                  rx_not_empty
);
    localparam int TPB = clock_freq / baud_rate;
    localparam int CW  = $clog2(TPB);
    localparam int BW  = (width > 1) ? $clog2(width) : 1;
    localparam logic [CW-1:0] TPB_LAST  = CW'(TPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(TPB / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(width - 1);
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;

    logic             tx_sel, rx_sel;
    logic             txf_empty, txf_full, tx_wr, tx_pop;
    logic             rxf_empty, rxf_full, rx_wr, rx_push, rx_pop;
    logic [width-1:0] txf_rdata, rxf_rdata;

    logic [1:0]       txs_q, txs_d, rxs_q, rxs_d;
    logic [CW-1:0]    txc_q, txc_d, rxc_q, rxc_d;
    logic [BW-1:0]    txb_q, txb_d, rxb_q, rxb_d;
    logic [width-1:0] txsh_q, txsh_d, rxsh_q, rxsh_d;
    logic             rxs1_q, rxs2_q;
    logic [width-1:0] dout_q;
    logic             dv_q;

    assign tx_sel = read_enable  && (active_address == addr_width'(tx_address));
    assign rx_sel = write_enable && (active_address == addr_width'(rx_address));
    // A same-cycle pop frees a slot, so a full FIFO still accepts the push.
    assign tx_wr  = tx_sel && (!txf_full || tx_pop);
    assign rx_pop = rx_sel && !rxf_empty;
    assign rx_wr  = rx_push && (!rxf_full || rx_pop);

    assign tx_full        = txf_full;
    assign rx_not_empty   = !rxf_empty;
    assign data_out       = dout_q;
    assign data_out_valid = dv_q;
    assign tx = (txs_q == START) ? 1'b0 : (txs_q == DATA) ? txsh_q[0] : 1'b1;

    buffered_uart_fifo #(.width(width), .depth(fifo_depth)) u_txf (
        .clock, .resetn, .push_i(tx_wr), .pop_i(tx_pop), .wdata_i(data_in),
        .rdata_o(txf_rdata), .full_o(txf_full), .empty_o(txf_empty));

    buffered_uart_fifo #(.width(width), .depth(fifo_depth)) u_rxf (
        .clock, .resetn, .push_i(rx_wr), .pop_i(rx_pop), .wdata_i(rxsh_q),
        .rdata_o(rxf_rdata), .full_o(rxf_full), .empty_o(rxf_empty));

    always_comb begin
        txs_d  = txs_q;
        txc_d  = txc_q + 1'b1;
        txb_d  = txb_q;
        txsh_d = txsh_q;
        tx_pop = 1'b0;
        case (txs_q)
            IDLE: begin
                txc_d = '0;
                if (!txf_empty) begin
                    tx_pop = 1'b1; txsh_d = txf_rdata; txs_d = START;
                end
            end
            START: if (txc_q == TPB_LAST) begin
                txc_d = '0; txb_d = '0; txs_d = DATA;
            end
            DATA: if (txc_q == TPB_LAST) begin
                txc_d  = '0;
                txsh_d = txsh_q >> 1;
                txb_d  = txb_q + 1'b1;
                if (txb_q == BIT_LAST) txs_d = STOP;
            end
            default: if (txc_q == TPB_LAST) begin
                // Chain straight into the next start bit so bursts have no idle gap.
                txc_d = '0;
                txs_d = IDLE;
                if (!txf_empty) begin
                    tx_pop = 1'b1; txsh_d = txf_rdata; txs_d = START;
                end
            end
        endcase
    end

    always_comb begin
        rxs_d   = rxs_q;
        rxc_d   = rxc_q + 1'b1;
        rxb_d   = rxb_q;
        rxsh_d  = rxsh_q;
        rx_push = 1'b0;
        case (rxs_q)
            IDLE: begin
                rxc_d = '0;
                if (!rxs2_q) rxs_d = START;
            end
            START: if (rxc_q == HALF_LAST) begin
                rxc_d = '0; rxb_d = '0;
                rxs_d = rxs2_q ? IDLE : DATA;
            end
            DATA: if (rxc_q == TPB_LAST) begin
                rxc_d  = '0;
                rxsh_d = {rxs2_q, rxsh_q[width-1:1]};
                rxb_d  = rxb_q + 1'b1;
                if (rxb_q == BIT_LAST) rxs_d = STOP;
            end
            default: if (rxc_q == TPB_LAST) begin
                rxc_d   = '0;
                rxs_d   = IDLE;
                rx_push = rxs2_q;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            txs_q <= IDLE; txc_q <= '0; txb_q <= '0; txsh_q <= '0;
            rxs_q <= IDLE; rxc_q <= '0; rxb_q <= '0; rxsh_q <= '0;
            rxs1_q <= 1'b1; rxs2_q <= 1'b1;
        end else begin
            txs_q <= txs_d; txc_q <= txc_d; txb_q <= txb_d; txsh_q <= txsh_d;
            rxs_q <= rxs_d; rxc_q <= rxc_d; rxb_q <= rxb_d; rxsh_q <= rxsh_d;
            rxs1_q <= rx;   rxs2_q <= rxs1_q;
        end
    end

`ifdef BUFF_UART_STATUS_EN
    logic             stat_sel, rx_ferr, ovr_q, ferr_q;
    logic [width-1:0] status_w;

    assign stat_sel = write_enable && (active_address == addr_width'(status_address));
    assign rx_ferr  = (rxs_q == STOP) && (rxc_q == TPB_LAST) && !rxs2_q;
    assign status_w = width'({(txs_q != IDLE), ferr_q, ovr_q, txf_full, !rxf_empty});

    // A new error in the same cycle as a status read stays visible.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            ovr_q  <= (rx_push && !rx_wr) || (ovr_q && !stat_sel);
            ferr_q <= rx_ferr || (ferr_q && !stat_sel);
        end
    end
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dout_q <= '0;
            dv_q   <= 1'b0;
        end else begin
            dv_q <= rx_pop;
            if (rx_pop) dout_q <= rxf_rdata;
`ifdef BUFF_UART_STATUS_EN
            if (stat_sel) begin
                dv_q   <= 1'b1;
                dout_q <= status_w;
            end
`endif
        end
    end
endmodule

// File: tb/tb_buffered_uart.sv
// Randomized self-checking bench for buffered_uart: serial frames and FIFO
// occupancy are predicted from the line protocol with queues and arithmetic.
module tb_buffered_uart;
  localparam int CF = 1_000_000, BR = 100_000, TPB = CF / BR, W = 8, DEPTH = 8;
  localparam int FRAME = 10 * TPB;

  logic clock = 1'b0, resetn = 1'b0, rx = 1'b1;
  logic read_enable = 1'b0, write_enable = 1'b0;
  logic [7:0] active_address = '0, data_in = '0;
  logic tx, data_out_valid, tx_full, rx_not_empty;
  logic [7:0] data_out;

  int total = 0, bad = 0, cyc = 0;
  byte unsigned tx_got[$];
  int tx_start[$];

  buffered_uart #(.clock_freq(CF), .baud_rate(BR), .width(W), .addr_width(8),
                  .rx_address(3), .tx_address(4), .fifo_depth(DEPTH)) dut (
    .clock(clock), .resetn(resetn), .rx(rx), .tx(tx),
    .active_address(active_address), .read_enable(read_enable),
    .write_enable(write_enable), .data_in(data_in), .data_out(data_out),
    .data_out_valid(data_out_valid), .tx_full(tx_full), .rx_not_empty(rx_not_empty));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // All drivers run right after a negedge; each call spans exactly one posedge.
  task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
    active_address = a; data_in = d; read_enable = 1'b1;
    @(negedge clock);
    read_enable = 1'b0;
  endtask

  task automatic host_rd(input logic [7:0] a, output logic v, output logic [7:0] d);
    active_address = a; write_enable = 1'b1;
    @(negedge clock);
    write_enable = 1'b0;
    v = data_out_valid; d = data_out;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stopb);
    rx = 1'b0; repeat (TPB) @(negedge clock);
    for (int b = 0; b < W; b++) begin
      rx = d[b]; repeat (TPB) @(negedge clock);
    end
    rx = stopb; repeat (TPB) @(negedge clock);
    rx = 1'b1;
  endtask

  task automatic decode_tx(input int n);
    int waited;
    logic [7:0] d;
    for (int f = 0; f < n; f++) begin
      waited = 0;
      while (tx !== 1'b0 && waited < 400) begin
        @(negedge clock); waited++;
      end
      if (tx !== 1'b0) begin
        chk("tx_frame_timeout", 32'd1, 32'd0);
        return;
      end
      tx_start.push_back(cyc);
      repeat (TPB / 2) @(negedge clock);
      chk("tx_start_bit", tx, 1'b0);
      for (int b = 0; b < W; b++) begin
        repeat (TPB) @(negedge clock);
        d[b] = tx;
      end
      repeat (TPB) @(negedge clock);
      chk("tx_stop_bit", tx, 1'b1);
      tx_got.push_back(d);
    end
  endtask

  task automatic quiet(input int n, input string tag);
    int errs;
    errs = 0;
    repeat (n) begin
      @(negedge clock);
      if (tx !== 1'b1) errs++;
    end
    chk(tag, errs, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int occ, free_at, errs;
    logic pop, acc, rv;
    logic [7:0] rd, d, last_dout;
    logic [9:0] fbits;
    byte unsigned exp_q[$];

    // Reset with rx low, then release with the line idle.
    rx = 1'b0; resetn = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_tx", tx, 1'b1);
    chk("rst_dv", data_out_valid, 1'b0);
    chk("rst_rne", rx_not_empty, 1'b0);
    chk("rst_txfull", tx_full, 1'b0);
    chk("rst_dout", data_out, 8'h00);
    rx = 1'b1; resetn = 1'b1;
    quiet(30, "rst_tx_quiet");
    chk("rst_rne_quiet", rx_not_empty, 1'b0);
    last_dout = 8'h00;

    // Exact waveform: start bit begins one cycle after the FIFO turns non-empty.
    host_wr(8'd4, 8'h0A);
    fbits = {1'b1, 8'h0A, 1'b0};
    for (int n = 0; n <= FRAME + 5; n++) begin
      chk("tx_wave", tx, (n == 0 || n > FRAME) ? 1'b1 : fbits[(n - 1) / TPB]);
      @(negedge clock);
    end

    d = 8'($urandom);
    host_wr(8'd4, d);
    decode_tx(1);
    chk("tx_rand", (tx_got.size() > 0) ? 32'(tx_got.pop_front()) : 32'hFFFF, d);

    // Burst of 10 words into an 8-deep FIFO while the serializer drains it.
    tx_got.delete(); tx_start.delete(); exp_q.delete();
    occ = 0; free_at = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          pop = (occ > 0) && (i >= free_at);
          acc = (occ < DEPTH) || pop;
          if (pop) begin occ--; free_at = i + FRAME; end
          if (acc) begin occ++; exp_q.push_back(8'(i + 1)); end
          host_wr(8'd4, 8'(i + 1));
          chk("burst_tx_full", tx_full, occ == DEPTH);
        end
      end
      decode_tx(9);
    join
    chk("burst_count", tx_got.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < tx_got.size(); k++)
      chk("burst_word", tx_got[k], exp_q[k]);
    for (int k = 1; k < tx_start.size(); k++)
      chk("burst_gap", tx_start[k] - tx_start[k-1], FRAME);
    quiet(2 * FRAME, "burst_no_extra");
    chk("burst_txfull_end", tx_full, 1'b0);

    // RX single frame and host read.
    send_rx(8'h3E, 1'b1);
    repeat (3) @(negedge clock);
    chk("rx_rne", rx_not_empty, 1'b1);
    host_rd(8'd3, rv, rd);
    chk("rx_dv", rv, 1'b1);
    chk("rx_data", rd, 8'h3E);
    last_dout = 8'h3E;
    @(negedge clock);
    chk("rx_dv_pulse", data_out_valid, 1'b0);
    chk("rx_rne_after", rx_not_empty, 1'b0);

    // Short glitch and bad stop bit produce nothing.
    rx = 1'b0; repeat (3) @(negedge clock); rx = 1'b1;
    repeat (30) @(negedge clock);
    chk("rx_glitch", rx_not_empty, 1'b0);
    send_rx(8'($urandom), 1'b0);
    repeat (30) @(negedge clock);
    chk("rx_frame_err", rx_not_empty, 1'b0);

    // Nine good frames with no reads: the model keeps the first DEPTH.
    exp_q.delete();
    for (int i = 0; i < 9; i++) begin
      d = 8'($urandom);
      send_rx(d, 1'b1);
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
    end
    repeat (5) @(negedge clock);
    chk("ovr_rne", rx_not_empty, 1'b1);
    for (int i = 0; i <= DEPTH; i++) begin
      host_rd(8'd3, rv, rd);
      if (exp_q.size() > 0) begin
        d = exp_q.pop_front();
        chk("ovr_dv", rv, 1'b1);
        chk("ovr_data", rd, d);
        last_dout = d;
      end else begin
        chk("ovr_empty_dv", rv, 1'b0);
        chk("ovr_empty_hold", rd, last_dout);
      end
    end
    chk("ovr_rne_end", rx_not_empty, 1'b0);

    // Enables at an unmapped address, then a read of the empty RX FIFO.
    active_address = 8'd7; data_in = 8'h77; read_enable = 1'b1; write_enable = 1'b1;
    @(negedge clock);
    read_enable = 1'b0; write_enable = 1'b0;
    chk("ign_dv", data_out_valid, 1'b0);
    chk("ign_txfull", tx_full, 1'b0);
    chk("ign_rne", rx_not_empty, 1'b0);
    quiet(FRAME, "ign_tx_quiet");
    host_rd(8'd3, rv, rd);
    chk("ign_empty_dv", rv, 1'b0);
    chk("ign_empty_hold", rd, last_dout);

    // Reset in the middle of a frame aborts it and flushes the queued word.
    host_wr(8'd4, 8'h00);
    host_wr(8'd4, 8'h00);
    repeat (30) @(negedge clock);
    chk("midrst_pre_tx", tx, 1'b0);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_txfull", tx_full, 1'b0);
    @(negedge clock);
    resetn = 1'b1;
    quiet(2 * FRAME, "midrst_quiet");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
